braille_cell_composer: RTL
==========================

BRAILLE_CELL_COMPOSER -- requirements
Module: braille_cell_composer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8 (power of two, 2..32), meaning committed-cell buffer depth.
REQ-002 The block SHALL have port clk  input  1  system clock (100 MHz), all state on rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port i_dot  input  6  one-clk-wide debounced pulses, bit k toggles Braille dot k+1.
REQ-005 The block SHALL have port i_enter  input  1  one-clk pulse, commits the current cell to the buffer.
REQ-006 The block SHALL have port i_bksp  input  1  one-clk pulse, backspace.
REQ-007 The block SHALL have port i_clear  input  1  one-clk pulse, clears the cell and the buffer.
REQ-008 The block SHALL have port o_cell  output  6  cell being edited, bit k = dot k+1 raised.
REQ-009 The block SHALL have port o_data  output  6  oldest committed cell (buffer head).
REQ-010 The block SHALL have port o_valid  output  1  o_data valid (buffer non-empty).
REQ-011 The block SHALL have port i_ready  input  1  consumer accepts o_data when o_valid&i_ready.
REQ-012 The block SHALL have port o_count  output  $clog2(DEPTH)+1  committed entries held.
REQ-013 The block SHALL have port o_full  output  1  o_count==DEPTH.
REQ-014 The block SHALL have port o_overflow  output  1  one-clk pulse, enter rejected because buffer full.

Function
REQ-015 The FSM SHALL have states S_BLANK (o_cell==0) and S_EDIT (o_cell!=0); the state SHALL be a registered decode of o_cell.
REQ-016 Per-cycle command priority SHALL be i_clear > i_bksp > i_enter > i_dot; lower-priority commands in the same cycle SHALL be dropped.
REQ-017 i_dot (no higher command) SHALL XOR into o_cell, visible the next cycle; multiple bits in one cycle SHALL all toggle.
REQ-018 i_enter when not full SHALL write o_cell at the tail and clear o_cell next cycle; o_valid SHALL rise the cycle after the write if the buffer was empty.
REQ-019 i_enter in S_BLANK SHALL commit 6'b000000 (space cell).
REQ-020 i_enter when full and no pop in the same cycle SHALL leave buffer and o_cell unchanged and pulse o_overflow for exactly one cycle.
REQ-021 i_enter when full with o_valid&i_ready in the same cycle SHALL be accepted (pop evaluated before push); o_count SHALL stay DEPTH.
REQ-022 Pop (o_valid&i_ready) SHALL advance the head by one, independent of edit commands, except as in REQ-024.
REQ-023 i_bksp in S_EDIT SHALL clear o_cell only; in S_BLANK it SHALL remove the newest entry (tail-1) if o_count>0, else no effect.
REQ-024 i_bksp in S_BLANK with o_count==1 and a pop in the same cycle: the pop SHALL win, the bksp SHALL be ignored.
REQ-025 i_clear SHALL zero o_cell and empty the buffer in one cycle; a concurrent pop SHALL be discarded.
REQ-026 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; o_count SHALL never exceed DEPTH or underflow.
REQ-027 o_data SHALL be driven from the buffer head combinationally from registered pointers; o_data SHALL be don't-care when o_valid==0.
REQ-028 o_valid, o_full and o_count SHALL be consistent in every cycle.

Reset
REQ-029 reset_n low SHALL asynchronously force o_cell=0, pointers=0, o_count=0, o_valid=0, o_full=0, o_overflow=0, state S_BLANK.
REQ-030 Reset mid-operation SHALL discard buffered cells; buffer RAM contents need no reset.
REQ-031 The first command after reset_n deassertion SHALL be honoured on the first clk edge.

Structure
REQ-032 A shared package SHALL hold the state encoding (S_BLANK, S_EDIT), the cell width constant (6) and the space-cell constant.
REQ-033 Storage SHALL be one sub-module braille_cell_lifo_fifo (head pop, tail push, tail unpush, flush); command decode and FSM SHALL stay in the top.

Verification
REQ-034 i_dot=6'b000001, then 6'b001000 pulses -> o_cell=6'b001001 one cycle after the second pulse; state S_EDIT.
REQ-035 o_cell=6'b001001, i_enter, i_ready=0 -> o_count=1, o_valid=1, o_data=6'b001001, o_cell=0 next cycle.
REQ-036 DEPTH=8: 8 enters with i_ready=0, then a 9th -> o_full=1, o_overflow high exactly one cycle, o_count=8; 9th enter with i_ready=1 -> accepted, o_count=8.
REQ-037 Buffer {A,B}, S_BLANK, i_bksp -> o_count=1, o_data=A; in S_EDIT, i_bksp -> o_cell=0, o_count unchanged.
REQ-038 i_clear and i_enter and i_dot in the same cycle with o_count=3 -> o_count=0, o_valid=0, o_cell=0, no overflow.
REQ-039 reset_n pulsed low mid-stream with o_count=5 -> all outputs 0 immediately (asynchronously), and a normal enter is accepted on the first edge after release.

Source files
------------

// File: rtl/braille_cell_composer_pkg.sv
// Shared types and constants for the Braille cell composer.
// Holds the editor state encoding and the cell geometry.
package braille_cell_composer_pkg;

    localparam int CELL_W = 6;
    localparam logic [CELL_W-1:0] SPACE_CELL = '0;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_EDIT  = 1'b1
    } state_t;

endpackage

// File: rtl/braille_cell_lifo_fifo.sv
// Committed-cell store: FIFO at the head, with a tail "unpush" so the
// newest entry can be withdrawn by backspace. Flush empties it in one cycle.
module braille_cell_lifo_fifo
    import braille_cell_composer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [CELL_W-1:0]        wdata,
    input  logic                     pop,
    input  logic                     unpush,
    input  logic                     flush,
    output logic [CELL_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CELL_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count_nxt;

    assign rdata = mem[head];

    always_comb begin
        count_nxt = count
                  + {{PW{1'b0}}, push}
                  - {{PW{1'b0}}, pop}
                  - {{PW{1'b0}}, unpush};
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[tail] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)
                head <= head + 1'b1;
            if (push)
                tail <= tail + 1'b1;
            else if (unpush)
                tail <= tail - 1'b1;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/braille_cell_composer.sv
// Six-dot Braille cell editor: dots toggle the working cell, enter commits
// it into a small buffer drained by a valid/ready consumer.
module braille_cell_composer
    import braille_cell_composer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [5:0]             i_dot,
    input  logic                   i_enter,
    input  logic                   i_bksp,
    input  logic                   i_clear,
    output logic [5:0]             o_cell,
    output logic [5:0]             o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    state_t            state;
    logic [CELL_W-1:0] cell_nxt;
    logic              ovf_nxt;
    logic              pop_req;
    logic              pop;
    logic              push;
    logic              unpush;
    logic              flush;

    assign o_valid = (o_count != '0);
    assign o_full  = (o_count == FULL_CNT);
    assign pop_req = o_valid & i_ready;

    always_comb begin
        cell_nxt = o_cell;
        ovf_nxt  = 1'b0;
        pop      = pop_req;
        push     = 1'b0;
        unpush   = 1'b0;
        flush    = 1'b0;
        if (i_clear) begin
            cell_nxt = SPACE_CELL;
            flush    = 1'b1;
            pop      = 1'b0;
        end else if (i_bksp) begin
            if (state == S_EDIT)
                cell_nxt = SPACE_CELL;
            // a lone entry being popped this cycle is already gone
            else if (o_valid && !(o_count == ONE_CNT && pop_req))
                unpush = 1'b1;
        end else if (i_enter) begin
            if (!o_full || pop_req) begin
                push     = 1'b1;
                cell_nxt = SPACE_CELL;
            end else begin
                ovf_nxt = 1'b1;
            end
        end else begin
            cell_nxt = o_cell ^ i_dot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_BLANK;
            o_cell     <= SPACE_CELL;
            o_overflow <= 1'b0;
        end else begin
            state      <= (cell_nxt != SPACE_CELL) ? S_EDIT : S_BLANK;
            o_cell     <= cell_nxt;
            o_overflow <= ovf_nxt;
        end
    end

    braille_cell_lifo_fifo #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (o_cell),
        .pop     (pop),
        .unpush  (unpush),
        .flush   (flush),
        .rdata   (o_data),
        .count   (o_count)
    );

endmodule
